// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: pulses PLL reset, waits for a synchronized stable lock, then releases downstream reset.
// Outputs registered, one cycle after the deciding edge; no backpressure, restart is a single-cycle request.
module pll_lock_supervisor #(
  parameter int RST_CYCLES     = 16,
  parameter int STABLE_CYCLES  = 1024,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic       fail,
  output logic [1:0] retries,
  output logic [2:0] state
);

  localparam int MAX_A = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int MAX_C = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] RST_LD  = CW'(RST_CYCLES);
  localparam logic [CW-1:0] STB_LD  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] TMO_LD  = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] ONE     = CW'(1);
  localparam logic [1:0]    MAX_RET = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_PLLRST    = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABILIZE = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAIL      = 3'd4
  } state_t;

  // Output bits are {pll_rst, sys_reset, ready, fail} for the state being entered.
  function automatic logic [3:0] decode(input state_t s);
    case (s)
      ST_PLLRST: return 4'b1100;
      ST_RUN:    return 4'b0010;
      ST_FAIL:   return 4'b0101;
      default:   return 4'b0100;
    endcase
  endfunction

  state_t        st;
  logic [CW-1:0] cnt;
  logic          sync_q1;
  logic          sync_q2;
  logic [3:0]    outs;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      st      <= ST_PLLRST;
      cnt     <= RST_LD;
      retries <= 2'd0;
      outs    <= decode(ST_PLLRST);
    end else begin
      sync_q1 <= pll_locked;
      sync_q2 <= sync_q1;
      if (restart) begin
        st      <= ST_PLLRST;
        cnt     <= RST_LD;
        retries <= 2'd0;
        outs    <= decode(ST_PLLRST);
      end else begin
        case (st)
          ST_PLLRST: begin
            if (cnt == ONE) begin
              st   <= ST_WAIT_LOCK;
              cnt  <= TMO_LD;
              outs <= decode(ST_WAIT_LOCK);
            end else begin
              cnt <= cnt - ONE;
            end
          end
          ST_WAIT_LOCK: begin
            // A lock seen on the last timeout cycle still wins over the timeout.
            if (sync_q2) begin
              st   <= ST_STABILIZE;
              cnt  <= STB_LD;
              outs <= decode(ST_STABILIZE);
            end else if (cnt == ONE) begin
              if (retries < MAX_RET) begin
                retries <= retries + 2'd1;
                st      <= ST_PLLRST;
                cnt     <= RST_LD;
                outs    <= decode(ST_PLLRST);
              end else begin
                st   <= ST_FAIL;
                outs <= decode(ST_FAIL);
              end
            end else begin
              cnt <= cnt - ONE;
            end
          end
          ST_STABILIZE: begin
            if (!sync_q2) begin
              st   <= ST_WAIT_LOCK;
              cnt  <= TMO_LD;
              outs <= decode(ST_WAIT_LOCK);
            end else if (cnt == ONE) begin
              st      <= ST_RUN;
              retries <= 2'd0;
              outs    <= decode(ST_RUN);
            end else begin
              cnt <= cnt - ONE;
            end
          end
          ST_RUN: begin
            if (!sync_q2) begin
              st   <= ST_PLLRST;
              cnt  <= RST_LD;
              outs <= decode(ST_PLLRST);
            end
          end
          ST_FAIL: begin
          end
          default: begin
            st   <= ST_PLLRST;
            cnt  <= RST_LD;
            outs <= decode(ST_PLLRST);
          end
        endcase
      end
    end
  end

  assign {pll_rst, sys_reset, ready, fail} = outs;
  assign state = st;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor: three parameterisations checked against an elapsed-time reference model.
// Directed scenario tasks followed by randomized lock/restart/reset traffic.
module tb_pll_lock_supervisor;

  logic clock;
  logic rn [3];
  logic lk [3];
  logic rs [3];

  logic       a_pr, a_sr, a_rd, a_fl;
  logic [1:0] a_rt;
  logic [2:0] a_st;
  logic       b_pr, b_sr, b_rd, b_fl;
  logic [1:0] b_rt;
  logic [2:0] b_st;
  logic       c_pr, c_sr, c_rd, c_fl;
  logic [1:0] c_rt;
  logic [2:0] c_st;
  logic [8:0] o0, o1, o2;

  assign o0 = {a_pr, a_sr, a_rd, a_fl, a_rt, a_st};
  assign o1 = {b_pr, b_sr, b_rd, b_fl, b_rt, b_st};
  assign o2 = {c_pr, c_sr, c_rd, c_fl, c_rt, c_st};

  int P_RST [3] = '{16, 16, 4};
  int P_STB [3] = '{1024, 32, 8};
  int P_TMO [3] = '{65536, 64, 16};
  int P_MAX [3] = '{3, 3, 0};

  // Reference model: phase number, cycles elapsed in phase, retry count, lock delay line.
  int   m_st  [3];
  int   m_el  [3];
  int   m_ret [3];
  logic m_p1  [3];
  logic m_p2  [3];

  int vecs  = 0;
  int fails = 0;

  pll_lock_supervisor u_dflt (
    .clock(clock), .reset_n(rn[0]), .pll_locked(lk[0]), .restart(rs[0]),
    .pll_rst(a_pr), .sys_reset(a_sr), .ready(a_rd), .fail(a_fl), .retries(a_rt), .state(a_st)
  );

  pll_lock_supervisor #(.RST_CYCLES(16), .STABLE_CYCLES(32), .TIMEOUT_CYCLES(64), .MAX_RETRIES(3)) u_tmo (
    .clock(clock), .reset_n(rn[1]), .pll_locked(lk[1]), .restart(rs[1]),
    .pll_rst(b_pr), .sys_reset(b_sr), .ready(b_rd), .fail(b_fl), .retries(b_rt), .state(b_st)
  );

  pll_lock_supervisor #(.RST_CYCLES(4), .STABLE_CYCLES(8), .TIMEOUT_CYCLES(16), .MAX_RETRIES(0)) u_zero (
    .clock(clock), .reset_n(rn[2]), .pll_locked(lk[2]), .restart(rs[2]),
    .pll_rst(c_pr), .sys_reset(c_sr), .ready(c_rd), .fail(c_fl), .retries(c_rt), .state(c_st)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [8:0] obs(input int k);
    case (k)
      0:       return o0;
      1:       return o1;
      default: return o2;
    endcase
  endfunction

  // Expected outputs follow directly from the phase: PLLRST=0 WAIT=1 STAB=2 RUN=3 FAIL=4.
  function automatic logic [8:0] expv(input int k);
    return {m_st[k] == 0, m_st[k] != 3, m_st[k] == 3, m_st[k] == 4, 2'(m_ret[k]), 3'(m_st[k])};
  endfunction

  task automatic m_reset(input int k);
    m_st[k]  = 0;
    m_el[k]  = 0;
    m_ret[k] = 0;
    m_p1[k]  = 1'b0;
    m_p2[k]  = 1'b0;
  endtask

  task automatic m_step(input int k);
    logic lock;
    lock    = m_p2[k];
    m_p2[k] = m_p1[k];
    m_p1[k] = lk[k];
    if (rs[k]) begin
      m_st[k] = 0; m_el[k] = 0; m_ret[k] = 0;
    end else begin
      case (m_st[k])
        0: begin
          m_el[k]++;
          if (m_el[k] == P_RST[k]) begin m_st[k] = 1; m_el[k] = 0; end
        end
        1: begin
          if (lock) begin
            m_st[k] = 2; m_el[k] = 0;
          end else begin
            m_el[k]++;
            if (m_el[k] == P_TMO[k]) begin
              m_el[k] = 0;
              if (m_ret[k] < P_MAX[k]) begin m_ret[k]++; m_st[k] = 0; end
              else m_st[k] = 4;
            end
          end
        end
        2: begin
          if (!lock) begin
            m_st[k] = 1; m_el[k] = 0;
          end else begin
            m_el[k]++;
            if (m_el[k] == P_STB[k]) begin m_st[k] = 3; m_el[k] = 0; m_ret[k] = 0; end
          end
        end
        3: if (!lock) begin m_st[k] = 0; m_el[k] = 0; end
        default: ;
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clock);
    for (int k = 0; k < 3; k++) begin
      if (rn[k]) m_step(k);
      else m_reset(k);
    end
    @(negedge clock);
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      rn[k] = 1'b1; lk[k] = 1'b0; rs[k] = 1'b0;
    end
    #1;
    for (int k = 0; k < 3; k++) begin
      rn[k] = 1'b0;
      m_reset(k);
    end
    #2;
    for (int k = 0; k < 3; k++) begin
      vecs++;
      if (obs(k) !== 9'h180) begin
        fails++; $display("FAIL reset_state dut%0d: got %h want %h", k, obs(k), 9'h180);
      end
      vecs++;
      if (obs(k) !== expv(k)) begin
        fails++; $display("FAIL reset_model dut%0d: got %h want %h", k, obs(k), expv(k));
      end
    end
    @(negedge clock);
    for (int k = 0; k < 3; k++) rn[k] = 1'b1;
  endtask

  task automatic test_nominal();
    int n;
    n = 0;
    while (a_pr && n < 64) begin
      n++; tick();
      vecs++; if (o0 !== expv(0)) begin fails++; $display("FAIL nominal_model t=%0t got %h want %h", $time, o0, expv(0)); end
    end
    vecs++; if (n != 16) begin fails++; $display("FAIL nominal_pll_rst_width got %0d want 16", n); end
    repeat (100) begin
      tick();
      vecs++; if (o0 !== expv(0)) begin fails++; $display("FAIL nominal_model t=%0t got %h want %h", $time, o0, expv(0)); end
    end
    lk[0] = 1'b1;
    n = 0;
    while (!a_rd && n < 2000) begin
      n++; tick();
      vecs++; if (o0 !== expv(0)) begin fails++; $display("FAIL nominal_model t=%0t got %h want %h", $time, o0, expv(0)); end
    end
    // Two synchronizer stages, one decision edge, then the full stable window.
    vecs++; if (n != 2 + 1 + 1024) begin fails++; $display("FAIL nominal_ready_latency got %0d want %0d", n, 1027); end
    vecs++; if ({a_sr, a_rd, a_rt} !== 4'b0100) begin fails++; $display("FAIL nominal_run_outputs got %b want 0100", {a_sr, a_rd, a_rt}); end
  endtask

  task automatic test_glitch();
    int   c;
    logic saw;
    rs[0] = 1'b1; tick(); rs[0] = 1'b0;
    vecs++; if ({a_st, a_rt} !== 5'b00000) begin fails++; $display("FAIL glitch_restart got %b want 00000", {a_st, a_rt}); end
    c = 0;
    while (a_st !== 3'd2 && c < 100) begin
      c++; tick();
      vecs++; if (o0 !== expv(0)) begin fails++; $display("FAIL glitch_model t=%0t got %h want %h", $time, o0, expv(0)); end
    end
    vecs++; if (a_st !== 3'd2) begin fails++; $display("FAIL glitch_reach_stabilize got %0d want 2", a_st); end
    repeat (500) begin
      tick();
      vecs++; if (o0 !== expv(0)) begin fails++; $display("FAIL glitch_model t=%0t got %h want %h", $time, o0, expv(0)); end
    end
    lk[0] = 1'b0; tick(); lk[0] = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 10 && !(saw && a_st === 3'd2); i++) begin
      tick();
      if (a_st === 3'd1) saw = 1'b1;
      vecs++; if (o0 !== expv(0)) begin fails++; $display("FAIL glitch_model t=%0t got %h want %h", $time, o0, expv(0)); end
    end
    vecs++; if (!(saw && a_st === 3'd2)) begin fails++; $display("FAIL glitch_back_to_wait got state %0d saw %0b want 2 1", a_st, saw); end
    vecs++; if (a_rt !== 2'd0) begin fails++; $display("FAIL glitch_retries got %0d want 0", a_rt); end
    c = 0;
    while (!a_rd && c < 2000) begin
      c++; tick();
      vecs++; if (o0 !== expv(0)) begin fails++; $display("FAIL glitch_model t=%0t got %h want %h", $time, o0, expv(0)); end
    end
    vecs++; if (c != 1024) begin fails++; $display("FAIL glitch_relock_latency got %0d want 1024", c); end
  endtask

  task automatic test_lock_loss();
    int n;
    lk[0] = 1'b0;
    n = 0;
    while (!(a_sr && !a_rd) && n < 10) begin
      n++; tick();
      vecs++; if (o0 !== expv(0)) begin fails++; $display("FAIL lockloss_model t=%0t got %h want %h", $time, o0, expv(0)); end
    end
    vecs++; if (n > 3 || a_st !== 3'd0) begin fails++; $display("FAIL lockloss_response got %0d cycles state %0d want <=3 state 0", n, a_st); end
    n = 0;
    while (a_pr && n < 64) begin
      n++; tick();
      vecs++; if (o0 !== expv(0)) begin fails++; $display("FAIL lockloss_model t=%0t got %h want %h", $time, o0, expv(0)); end
    end
    vecs++; if (n != 16) begin fails++; $display("FAIL lockloss_pll_rst_width got %0d want 16", n); end
    lk[0] = 1'b1;
    n = 0;
    while (!a_rd && n < 2000) begin
      n++; tick();
      vecs++; if (o0 !== expv(0)) begin fails++; $display("FAIL lockloss_model t=%0t got %h want %h", $time, o0, expv(0)); end
    end
    vecs++; if (n != 1027 || a_rt !== 2'd0) begin fails++; $display("FAIL lockloss_rerun got %0d cycles retries %0d want 1027 0", n, a_rt); end
  endtask

  task automatic test_restart_priority();
    int c;
    rs[0] = 1'b1; tick(); rs[0] = 1'b0;
    c = 0;
    while (a_st !== 3'd2 && c < 100) begin
      c++; tick();
      vecs++; if (o0 !== expv(0)) begin fails++; $display("FAIL prio_model t=%0t got %h want %h", $time, o0, expv(0)); end
    end
    repeat (1023) begin
      tick();
      vecs++; if (o0 !== expv(0)) begin fails++; $display("FAIL prio_model t=%0t got %h want %h", $time, o0, expv(0)); end
    end
    vecs++; if (a_st !== 3'd2 || a_rd !== 1'b0) begin fails++; $display("FAIL prio_pre_state got %0d ready %0b want 2 0", a_st, a_rd); end
    // This edge would otherwise complete the stable window.
    rs[0] = 1'b1; tick(); rs[0] = 1'b0;
    vecs++; if ({a_st, a_rt, a_pr, a_rd} !== 7'b0000010) begin fails++; $display("FAIL prio_restart_wins got %b want 0000010", {a_st, a_rt, a_pr, a_rd}); end
    c = 0;
    while (!a_rd && c < 2000) begin
      c++; tick();
      vecs++; if (o0 !== expv(0)) begin fails++; $display("FAIL prio_model t=%0t got %h want %h", $time, o0, expv(0)); end
    end
    vecs++; if (a_rd !== 1'b1) begin fails++; $display("FAIL prio_rerun_ready got %0b want 1", a_rd); end
  endtask

  task automatic test_async_reset();
    int n;
    vecs++; if (a_rd !== 1'b1) begin fails++; $display("FAIL async_pre_run got %0b want 1", a_rd); end
    #2 rn[0] = 1'b0;
    m_reset(0);
    #1;
    vecs++; if (o0 !== 9'h180) begin fails++; $display("FAIL async_immediate got %h want %h", o0, 9'h180); end
    #1 rn[0] = 1'b1;
    n = 0;
    while (a_pr && n < 64) begin
      n++; tick();
      vecs++; if (o0 !== expv(0)) begin fails++; $display("FAIL async_model t=%0t got %h want %h", $time, o0, expv(0)); end
    end
    vecs++; if (n != 16) begin fails++; $display("FAIL async_pll_rst_width got %0d want 16", n); end
  endtask

  task automatic test_timeouts();
    int   pulses;
    int   c;
    logic prev;
    lk[1] = 1'b0; rs[1] = 1'b0;
    #2 rn[1] = 1'b0;
    m_reset(1);
    #2 rn[1] = 1'b1;
    pulses = 0; prev = 1'b0; c = 0;
    while (!b_fl && c < 800) begin
      if (b_pr && !prev) begin
        vecs++; if (b_rt !== 2'(pulses)) begin fails++; $display("FAIL timeout_retries_at_pulse got %0d want %0d", b_rt, pulses); end
        pulses++;
      end
      prev = b_pr;
      c++; tick();
      vecs++; if (o1 !== expv(1)) begin fails++; $display("FAIL timeout_model t=%0t got %h want %h", $time, o1, expv(1)); end
    end
    vecs++; if (pulses != 4) begin fails++; $display("FAIL timeout_pulse_count got %0d want 4", pulses); end
    vecs++; if (c != 4 * (16 + 64)) begin fails++; $display("FAIL timeout_fail_time got %0d want 320", c); end
    vecs++; if ({b_fl, b_pr, b_sr, b_rd, b_rt} !== 6'b101011) begin fails++; $display("FAIL timeout_fail_outputs got %b want 101011", {b_fl, b_pr, b_sr, b_rd, b_rt}); end
    rs[1] = 1'b1; tick(); rs[1] = 1'b0;
    vecs++; if ({b_st, b_rt, b_fl, b_pr} !== 7'b0000001) begin fails++; $display("FAIL fail_restart got %b want 0000001", {b_st, b_rt, b_fl, b_pr}); end
  endtask

  task automatic test_zero_retries();
    int c;
    lk[2] = 1'b0; rs[2] = 1'b0;
    #2 rn[2] = 1'b0;
    m_reset(2);
    #2 rn[2] = 1'b1;
    c = 0;
    while (!c_fl && c < 100) begin
      c++; tick();
      vecs++; if (o2 !== expv(2)) begin fails++; $display("FAIL zero_model t=%0t got %h want %h", $time, o2, expv(2)); end
    end
    vecs++; if (c != 4 + 16 || c_rt !== 2'd0) begin fails++; $display("FAIL zero_first_timeout got %0d cycles retries %0d want 20 0", c, c_rt); end
  endtask

  task automatic test_random();
    int hold [3];
    for (int k = 0; k < 3; k++) hold[k] = 0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      for (int k = 0; k < 3; k++) begin
        if (hold[k] == 0) begin
          lk[k]   = ~lk[k];
          hold[k] = lk[k] ? int'($urandom_range(1, 150)) : int'($urandom_range(1, 90));
        end else begin
          hold[k]--;
        end
        rs[k] = ($urandom_range(0, 99) == 0);
      end
      if ($urandom_range(0, 299) == 0) begin
        int k;
        k = int'($urandom_range(0, 2));
        #2 rn[k] = 1'b0;
        m_reset(k);
        #1;
        vecs++; if (obs(k) !== expv(k)) begin fails++; $display("FAIL random_async dut%0d got %h want %h", k, obs(k), expv(k)); end
        #1 rn[k] = 1'b1;
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        vecs++; if (obs(k) !== expv(k)) begin fails++; $display("FAIL random_model dut%0d t=%0t got %h want %h", k, $time, obs(k), expv(k)); end
      end
    end
    for (int k = 0; k < 3; k++) rs[k] = 1'b0;
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_glitch();
    test_lock_loss();
    test_restart_priority();
    test_async_reset();
    test_timeouts();
    test_zero_retries();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
